pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_skid_reg.sv | 98 +++++++++
 tb/tb_pipe_skid_reg.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: global widths,
// skid-register state encoding and occupancy helper.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_t;

  function automatic logic [OCC_W-1:0] occ_of(
    input skid_state_t s
  );
    logic [OCC_W-1:0] o;
    o = '0;
    unique case (s)
      EMPTY:   o = 2'd0;
      FULL:    o = 2'd1;
      SKID:    o = 2'd2;
      default: o = 2'd0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sync clear.
// Ports: clk, rst (async low), inc, clr, cnt[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register, valid/ready both sides.
// Ports: clk, rst, flush, in_*, out_*, occ, stall_cnt.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = XLEN + ILEN,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_t st, st_nx;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      st     <= st_nx;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    st_nx  = st;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      st_nx  = EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      unique case (st)
        EMPTY: begin
          if (in_valid) begin
            main_d = in_data;
            st_nx  = FULL;
          end
        end
        FULL: begin
          unique case (1'b1)
            in_valid && out_ready: begin
              main_d = in_data;
            end
            in_valid && !out_ready: begin
              skid_d = in_data;
              st_nx  = SKID;
            end
            !in_valid && out_ready: begin
              st_nx = EMPTY;
            end
            default: ;
          endcase
        end
        SKID: begin
          // head leaves; skid entry moves up
          if (out_ready) begin
            main_d = skid_q;
            skid_d = BUBBLE;
            st_nx  = FULL;
          end
        end
        default: st_nx = EMPTY;
      endcase
    end
  end

  assign in_ready  = (st != SKID);
  assign out_valid = (st != EMPTY);
  assign occ       = occ_of(st);
  assign out_data  = out_valid ? main_q : BUBBLE;

  sat_counter #(
    .W(CNT_W)
  ) u_stall (
    .clk(clk),
    .rst(rst),
    .inc(out_valid && !out_ready),
    .clr(1'b0),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg (CNT_W=4).
// Linear stimulus, immediate assertions per check.
module tb_pipe_skid_reg;

  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int exp_stall;

  always #5 clk = ~clk;

  pipe_skid_reg #(
    .DATA_W(DW),
    .BUBBLE('0),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occ(occ),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic [DW-1:0] d,
                         input logic [1:0] o,
                         input logic r,
                         input int s);
    chk({tag, ".valid"}, DW'(out_valid), DW'(v));
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".occ"}, DW'(occ), DW'(o));
    chk({tag, ".ready"}, DW'(in_ready), DW'(r));
    chk({tag, ".stall"}, DW'(stall_cnt), DW'(s));
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    out_ready = 1'b0;

    // reset held 3 cycles with input offered
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset", 1'b0, '0, 2'd0, 1'b1, 0);
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    chk_out("post_rst", 1'b0, '0, 2'd0, 1'b1, 0);

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      chk_out($sformatf("stream%0d", i),
              1'b1, DW'(i), 2'd1, 1'b1, 0);
    end
    in_valid = 1'b0;
    step();
    chk_out("stream_end", 1'b0, '0, 2'd0, 1'b1, 0);

    // backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    step();
    chk_out("bp_a", 1'b1, 64'hA, 2'd1, 1'b1, 0);
    in_data = 64'hB;
    step();
    chk_out("bp_b", 1'b1, 64'hA, 2'd2, 1'b0, 1);
    in_valid = 1'b0;
    step();
    chk_out("bp_hold", 1'b1, 64'hA, 2'd2, 1'b0, 2);
    out_ready = 1'b1;
    step();
    chk_out("bp_drain1", 1'b1, 64'hB, 2'd1, 1'b1, 2);
    step();
    chk_out("bp_drain2", 1'b0, '0, 2'd0, 1'b1, 2);

    // flush in SKID with input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hC;
    step();
    chk_out("fl_c", 1'b1, 64'hC, 2'd1, 1'b1, 2);
    in_data = 64'hD;
    step();
    chk_out("fl_d", 1'b1, 64'hC, 2'd2, 1'b0, 3);
    in_data = 64'hE;
    flush   = 1'b1;
    step();
    chk_out("flush", 1'b0, '0, 2'd0, 1'b1, 4);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("fl_after", 1'b0, '0, 2'd0, 1'b1, 4);

    // saturation
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hF;
    step();
    chk_out("sat_load", 1'b1, 64'hF, 2'd1, 1'b1, 4);
    in_valid  = 1'b0;
    exp_stall = 4;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_stall < 15) exp_stall++;
      chk("sat_cnt", DW'(stall_cnt), DW'(exp_stall));
    end
    chk("sat_val", DW'(stall_cnt), 64'd15);
    step();
    chk("sat_hold", DW'(stall_cnt), 64'd15);

    // async reset mid-SKID
    in_valid = 1'b1;
    in_data  = 64'h11;
    step();
    in_data = 64'h22;
    step();
    chk_out("ar_skid", 1'b1, 64'hF, 2'd2, 1'b0, 15);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_out("ar_async", 1'b0, '0, 2'd0, 1'b1, 0);
    step();
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h33;
    step();
    chk_out("ar_first", 1'b1, 64'h33, 2'd1, 1'b1, 0);
    in_valid = 1'b0;
    step();
    chk_out("ar_empty", 1'b0, '0, 2'd0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
